// File: rtl/smg_pkg.sv
// Shared constants, state type and timing helpers for the 7-segment scan controller.
package smg_pkg;

    // Segment bus value with every segment (and the dp) dark.
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low {dp, g..a} patterns for hex 0..F with the dp off; entry 0 is the rightmost.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic {
        BLANK,
        DRIVE
    } scan_state_e;

    // Clock cycles in one digit slot.
    function automatic int calc_slot_cyc(input int clk_hz, input int scan_hz);
        return clk_hz / scan_hz;
    endfunction

    // Cycles per brightness step: the drive window is split into 16 equal steps.
    function automatic int calc_sub(input int slot_cyc, input int blank_cyc);
        return (slot_cyc - blank_cyc) / 16;
    endfunction

endpackage

// File: rtl/smg_hex_decoder.sv
// Nibble + decimal point + blank to an active-low 8-bit segment pattern.
module smg_hex_decoder
    import smg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    // Table lookup; a blanked digit stays fully dark including its dp.
    always_comb begin
        seg = SEG_OFF;
        if (!blank) begin
            seg = {~dp, HEX_SEG[nibble][6:0]};
        end
    end

endmodule

// File: rtl/smg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: shadow-buffered frames swapped at frame
// boundaries, blanking dead-time at the start of every slot and 16-level PWM brightness.
module smg_scan_ctrl
    import smg_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SCAN_HZ   = 1000,
    parameter int NUM_DIG   = 3,
    parameter int BLANK_CYC = 64
) (
    input  logic                   SYS_CLK,
    input  logic                   RESET,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NUM_DIG-1:0]   in_data,
    input  logic [NUM_DIG-1:0]     in_dp,
    input  logic [NUM_DIG-1:0]     in_blank,
    input  logic [3:0]             bright,
    output logic [7:0]             SMG_SEG,
    output logic [NUM_DIG-1:0]     SMG_DIG,
    output logic                   frame_sync
);

    localparam int SLOT_CYC = calc_slot_cyc(CLK_HZ, SCAN_HZ);
    localparam int SUB      = calc_sub(SLOT_CYC, BLANK_CYC);
    localparam int CNT_W    = $clog2(SLOT_CYC);
    localparam int IDX_W    = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LEN  = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIG - 1);

    // The slot must hold the dead-time plus at least one cycle per brightness step.
    generate
        if (SLOT_CYC < BLANK_CYC + 16) begin : g_bad_timing
            $error("smg_scan_ctrl: SLOT_CYC must be at least BLANK_CYC + 16");
        end
    endgenerate

    scan_state_e            state_q, state_d;
    logic [CNT_W-1:0]       slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [3:0]             bright_q, bright_d;
    logic [4*NUM_DIG-1:0]   shadow_data_q, shadow_data_d;
    logic [NUM_DIG-1:0]     shadow_dp_q, shadow_dp_d;
    logic [NUM_DIG-1:0]     shadow_blank_q, shadow_blank_d;
    logic                   shadow_full_q, shadow_full_d;
    logic [4*NUM_DIG-1:0]   act_data_q, act_data_d;
    logic [NUM_DIG-1:0]     act_dp_q, act_dp_d;
    logic [NUM_DIG-1:0]     act_blank_q, act_blank_d;
    logic [7:0]             seg_q, seg_d;
    logic [NUM_DIG-1:0]     dig_q, dig_d;
    logic                   frame_sync_q, frame_sync_d;

    logic                   slot_wrap;
    logic                   frame_end;
    logic                   accept;
    logic [CNT_W-1:0]       drive_cnt;
    int                     on_limit;
    logic                   digit_on;
    logic [3:0]             cur_nibble;
    logic                   cur_dp;
    logic                   cur_blank;
    logic [7:0]             dec_seg;

    assign slot_wrap  = (slot_cnt_q == SLOT_LAST);
    assign frame_end  = slot_wrap && (idx_q == IDX_LAST);
    assign in_ready   = ~shadow_full_q;
    assign accept     = in_valid && ~shadow_full_q;
    assign cur_nibble = act_data_q[idx_q*4 +: 4];
    assign cur_dp     = act_dp_q[idx_q];
    assign cur_blank  = act_blank_q[idx_q];

    smg_hex_decoder u_dec (
        .nibble (cur_nibble),
        .dp     (cur_dp),
        .blank  (cur_blank),
        .seg    (dec_seg)
    );

    // All state registers; reset darkens the pins immediately and drops any pending frame.
    always_ff @(posedge SYS_CLK or posedge RESET) begin
        if (RESET) begin
            state_q        <= BLANK;
            slot_cnt_q     <= '0;
            idx_q          <= '0;
            bright_q       <= '0;
            shadow_data_q  <= '0;
            shadow_dp_q    <= '0;
            shadow_blank_q <= '1;
            shadow_full_q  <= 1'b0;
            act_data_q     <= '0;
            act_dp_q       <= '0;
            act_blank_q    <= '1;
            seg_q          <= SEG_OFF;
            dig_q          <= '1;
            frame_sync_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            slot_cnt_q     <= slot_cnt_d;
            idx_q          <= idx_d;
            bright_q       <= bright_d;
            shadow_data_q  <= shadow_data_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blank_q <= shadow_blank_d;
            shadow_full_q  <= shadow_full_d;
            act_data_q     <= act_data_d;
            act_dp_q       <= act_dp_d;
            act_blank_q    <= act_blank_d;
            seg_q          <= seg_d;
            dig_q          <= dig_d;
            frame_sync_q   <= frame_sync_d;
        end
    end

    // Slot timing FSM: dead-time, then drive; brightness is captured just before driving.
    always_comb begin
        state_d    = state_q;
        slot_cnt_d = slot_cnt_q + 1'b1;
        idx_d      = idx_q;
        bright_d   = bright_q;
        if (slot_wrap) begin
            state_d    = BLANK;
            slot_cnt_d = '0;
            idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else if (slot_cnt_q == BLANK_LAST) begin
            state_d  = DRIVE;
            bright_d = bright;
        end
    end

    // Frame buffering: accept into the shadow, promote it to the active frame only at a boundary.
    always_comb begin
        shadow_data_d  = shadow_data_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_blank_d = shadow_blank_q;
        shadow_full_d  = shadow_full_q;
        act_data_d     = act_data_q;
        act_dp_d       = act_dp_q;
        act_blank_d    = act_blank_q;
        if (accept) begin
            shadow_data_d  = in_data;
            shadow_dp_d    = in_dp;
            shadow_blank_d = in_blank;
            shadow_full_d  = 1'b1;
        end else if (frame_end && shadow_full_q) begin
            act_data_d    = shadow_data_q;
            act_dp_d      = shadow_dp_q;
            act_blank_d   = shadow_blank_q;
            shadow_full_d = 1'b0;
        end
    end

    // Pin values: the current digit is lit only inside its PWM window and when not blanked.
    always_comb begin
        drive_cnt    = slot_cnt_q - BLANK_LEN;
        on_limit     = (int'(bright_q) + 1) * SUB;
        digit_on     = (state_q == DRIVE) && (int'(drive_cnt) < on_limit) && !cur_blank;
        seg_d        = SEG_OFF;
        dig_d        = '1;
        frame_sync_d = frame_end;
        if (digit_on) begin
            seg_d        = dec_seg;
            dig_d[idx_q] = 1'b0;
        end
    end

    assign SMG_SEG    = seg_q;
    assign SMG_DIG    = dig_q;
    assign frame_sync = frame_sync_q;

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// Scoreboard bench for smg_scan_ctrl: SLOT_CYC=40, SUB=2, three digits.
module tb_smg_scan_ctrl;

   logic        SYS_CLK = 1'b0;
   logic        RESET;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] in_data;
   logic [2:0]  in_dp;
   logic [2:0]  in_blank;
   logic [3:0]  bright;
   logic [7:0]  SMG_SEG;
   logic [2:0]  SMG_DIG;
   logic        frame_sync;

   int errors = 0;
   int checks = 0;
   int frameNo = -1;

   // One expected digit slot, keyed by the observed frame number and slot position.
   typedef struct {
      int         frame;
      int         slot;
      logic [2:0] dig;
      logic [7:0] seg;
      int         onCycles;
   } exp_t;

   exp_t expQ[$];

   smg_scan_ctrl #(
      .CLK_HZ    (4000),
      .SCAN_HZ   (100),
      .NUM_DIG   (3),
      .BLANK_CYC (8)
   ) dut (
      .SYS_CLK    (SYS_CLK),
      .RESET      (RESET),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_dp      (in_dp),
      .in_blank   (in_blank),
      .bright     (bright),
      .SMG_SEG    (SMG_SEG),
      .SMG_DIG    (SMG_DIG),
      .frame_sync (frame_sync)
   );

   // 10-unit clock period; outputs are sampled on the falling edge.
   always #5 SYS_CLK = ~SYS_CLK;

   // Single comparison point: every check counts here and reports mismatches.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Queue expectations for a whole frame; en selects which digits should light.
   task automatic pushFrame(input int f, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [2:0] en, input int onCycles);
      logic [7:0] segs [3];
      exp_t e;
      segs[0] = s0;
      segs[1] = s1;
      segs[2] = s2;
      for (int k = 0; k < 3; k++) begin
         e.frame = f;
         e.slot  = k;
         if (en[k]) begin
            e.dig      = 3'b111;
            e.dig[k]   = 1'b0;
            e.seg      = segs[k];
            e.onCycles = onCycles;
         end else begin
            e.dig      = 3'b111;
            e.seg      = 8'hFF;
            e.onCycles = 0;
         end
         expQ.push_back(e);
      end
   endtask

   // Compare one observed slot summary with the matching queued expectation, if any.
   task automatic scoreSlot(input int slot, input int onCnt, input int startPos,
                            input logic [2:0] digSeen, input logic [7:0] segSeen, input bit dirty);
      exp_t e;
      while (expQ.size() > 0 &&
             (expQ[0].frame < frameNo || (expQ[0].frame == frameNo && expQ[0].slot < slot))) begin
         checks++;
         errors++;
         $display("[TB] FAIL missed_slot: frame %0d slot %0d never observed, now at frame %0d",
                  expQ[0].frame, expQ[0].slot, frameNo);
         void'(expQ.pop_front());
      end
      if (expQ.size() > 0 && expQ[0].frame == frameNo && expQ[0].slot == slot) begin
         e = expQ.pop_front();
         checkOutput($sformatf("f%0d_s%0d_dig", frameNo, slot), 32'(digSeen), 32'(e.dig));
         checkOutput($sformatf("f%0d_s%0d_seg", frameNo, slot), 32'(segSeen), 32'(e.seg));
         checkOutput($sformatf("f%0d_s%0d_on_cycles", frameNo, slot), onCnt, e.onCycles);
         checkOutput($sformatf("f%0d_s%0d_clean", frameNo, slot), 32'(dirty), 32'd0);
         if (e.onCycles > 0) begin
            checkOutput($sformatf("f%0d_s%0d_on_start", frameNo, slot), startPos, 8);
         end
      end
   endtask

   // Monitor: aligns on frame_sync, summarises each 40-cycle slot and scores it.
   initial begin : monitor
      int         onCnt;
      int         startPos;
      int         lastPos;
      int         pos;
      logic [2:0] digSeen;
      logic [7:0] segSeen;
      bit         dirty;
      bit         fsOk;
      bit         abort;
      onCnt = 0; startPos = 0; lastPos = -1; digSeen = 3'b111; segSeen = 8'hFF; dirty = 0;
      forever begin
         @(negedge SYS_CLK);
         while (!(frame_sync === 1'b1 && RESET === 1'b0)) @(negedge SYS_CLK);
         abort = 0;
         while (!abort) begin
            frameNo++;
            fsOk = 1;
            for (int j = 0; j < 120 && !abort; j++) begin
               @(negedge SYS_CLK);
               if (RESET === 1'b1) begin
                  abort = 1;
               end else begin
                  pos = j % 40;
                  if (pos == 0) begin
                     onCnt = 0; startPos = 0; lastPos = -1;
                     digSeen = 3'b111; segSeen = 8'hFF; dirty = 0;
                  end
                  if (SMG_DIG !== 3'b111) begin
                     if (onCnt == 0) begin
                        startPos = pos;
                        digSeen  = SMG_DIG;
                        segSeen  = SMG_SEG;
                     end else if (SMG_DIG !== digSeen || SMG_SEG !== segSeen || lastPos != pos - 1) begin
                        dirty = 1;
                     end
                     onCnt++;
                     lastPos = pos;
                  end else if (SMG_SEG !== 8'hFF) begin
                     dirty = 1;
                  end
                  if ((frame_sync === 1'b1) != (j == 119)) fsOk = 0;
                  if (pos == 39) scoreSlot(j / 40, onCnt, startPos, digSeen, segSeen, dirty);
               end
            end
            if (!abort) checkOutput($sformatf("f%0d_frame_sync_period", frameNo), 32'(fsOk), 32'd1);
         end
      end
   end

   // Wait (bounded) until the monitor has started observing frame n.
   task automatic waitFrame(input int n);
      for (int i = 0; i < 2000; i++) begin
         @(posedge SYS_CLK);
         #1;
         if (frameNo >= n) return;
      end
      checks++;
      errors++;
      $display("[TB] FAIL wait_frame_timeout: frame %0d, required frame %0d", frameNo, n);
   endtask

   // Offer a frame and hold it until accepted; reports whether frame_sync was high on the accept cycle.
   task automatic applyStimulus(input logic [11:0] data, input logic [2:0] dp, input logic [2:0] blank,
                                output bit fsAtAccept);
      bit readySeen;
      bit fsSeen;
      bit done;
      done = 0;
      fsAtAccept = 0;
      in_data  = data;
      in_dp    = dp;
      in_blank = blank;
      in_valid = 1'b1;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge SYS_CLK);
         readySeen = (in_ready === 1'b1);
         fsSeen    = (frame_sync === 1'b1);
         @(posedge SYS_CLK);
         #1;
         if (readySeen) begin
            done = 1;
            fsAtAccept = fsSeen;
         end
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: in_ready stayed 0, required 1 within 400 cycles");
      end
   endtask

   // Directed scenario: idle frames, load/brightness, backpressure, dp/blank, async reset.
   initial begin : stimulus
      bit fs;
      bit lit;
      int k;
      RESET    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      in_dp    = '0;
      in_blank = '0;
      bright   = 4'd0;

      repeat (3) @(negedge SYS_CLK);
      checkOutput("reset_seg", 32'(SMG_SEG), 32'hFF);
      checkOutput("reset_dig", 32'(SMG_DIG), 32'h7);
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset_frame_sync", 32'(frame_sync), 32'd0);
      @(posedge SYS_CLK);
      #1 RESET = 1'b0;

      pushFrame(0, 8'hFF, 8'hFF, 8'hFF, 3'b000, 0);
      pushFrame(1, 8'hFF, 8'hFF, 8'hFF, 3'b000, 0);

      waitFrame(1);
      bright = 4'd15;
      applyStimulus(12'h210, 3'b000, 3'b000, fs);
      pushFrame(2, 8'hC0, 8'hF9, 8'hA4, 3'b111, 32);

      waitFrame(3);
      bright = 4'd0;
      pushFrame(3, 8'hC0, 8'hF9, 8'hA4, 3'b111, 2);

      waitFrame(4);
      bright = 4'd7;
      pushFrame(4, 8'hC0, 8'hF9, 8'hA4, 3'b111, 16);

      waitFrame(5);
      applyStimulus(12'h543, 3'b000, 3'b000, fs);
      @(negedge SYS_CLK);
      checkOutput("shadow_full_in_ready", 32'(in_ready), 32'd0);
      pushFrame(6, 8'hB0, 8'h99, 8'h92, 3'b111, 16);
      pushFrame(7, 8'h82, 8'hF8, 8'h80, 3'b111, 16);
      applyStimulus(12'h876, 3'b000, 3'b000, fs);
      checkOutput("held_frame_accept_at_boundary", 32'(fs), 32'd1);

      waitFrame(7);
      applyStimulus(12'hFEF, 3'b010, 3'b100, fs);
      pushFrame(8, 8'h8E, 8'h06, 8'hFF, 3'b011, 16);

      waitFrame(9);
      applyStimulus(12'h999, 3'b000, 3'b000, fs);
      lit = 0;
      for (int i = 0; i < 200 && !lit; i++) begin
         @(negedge SYS_CLK);
         lit = (SMG_DIG !== 3'b111);
      end
      checkOutput("drive_before_reset", 32'(lit), 32'd1);
      #2 RESET = 1'b1;
      #1;
      checkOutput("async_reset_seg", 32'(SMG_SEG), 32'hFF);
      checkOutput("async_reset_dig", 32'(SMG_DIG), 32'h7);
      checkOutput("async_reset_in_ready", 32'(in_ready), 32'd1);
      k = frameNo;
      repeat (2) @(posedge SYS_CLK);
      #1 RESET = 1'b0;
      pushFrame(k + 1, 8'hFF, 8'hFF, 8'hFF, 3'b000, 0);
      pushFrame(k + 2, 8'hFF, 8'hFF, 8'hFF, 3'b000, 0);

      waitFrame(k + 3);
      checkOutput("expectations_drained", 32'(expQ.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
